// File: rtl/rv64g_reg_scoreboard.sv
// rv64g_reg_scoreboard: per-register saturating outstanding-write counters driving the issue lock vector.
// Define RV64G_SCOREBOARD_EARLY_RELEASE_EN to mask locks with the current-cycle writebacks.
module rv64g_reg_scoreboard #(
  parameter int NR = 64,
  parameter int WB = 2,
  parameter int CW = 2,
  localparam int RW = $clog2(NR)
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             clear_i,
  input  logic             launch_valid_i,
  output logic             launch_ready_o,
  input  logic             launch_wr_en_i,
  input  logic [RW-1:0]    launch_rd_i,
  input  logic [WB-1:0]    wb_valid_i,
  input  logic [WB*RW-1:0] wb_rd_i,
  output logic [NR-1:0]    locks_o,
  output logic             busy_o,
  output logic             err_o
);
  localparam int HW = $clog2(WB + 1);
  localparam int SW = (CW + 1 > HW) ? CW + 1 : HW;
  localparam logic [CW-1:0] MAX = '1;
  logic [NR-1:0][CW-1:0] r_cnt, w_nxt;
  logic [NR-1:0] w_uf, w_locks;
  logic [SW-1:0] w_h, w_s;
  logic r_err, w_fire;
  // Saturation is judged on the pre-update count, even if a writeback frees a slot this cycle.
  assign launch_ready_o = !(launch_wr_en_i && r_cnt[launch_rd_i] == MAX);
  assign w_fire = launch_valid_i && launch_ready_o && launch_wr_en_i && launch_rd_i != '0;
  always_comb begin
    w_nxt = '0;
    w_uf = '0;
    w_locks = '0;
    w_h = '0;
    w_s = '0;
    for (int r = 1; r < NR; r++) begin
      w_h = '0;
      for (int p = 0; p < WB; p++)
        if (wb_valid_i[p] && wb_rd_i[p*RW +: RW] == RW'(r)) w_h = w_h + SW'(1);
      w_s = SW'(r_cnt[r]) + SW'(w_fire && launch_rd_i == RW'(r));
      w_uf[r] = w_h > w_s;
      w_nxt[r] = w_uf[r] ? '0 : CW'(w_s - w_h);
`ifdef RV64G_SCOREBOARD_EARLY_RELEASE_EN
      w_locks[r] = r_cnt[r] != '0 && w_h < SW'(r_cnt[r]);
`else
      w_locks[r] = r_cnt[r] != '0;
`endif
    end
  end
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (clear_i) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_nxt;
      r_err <= r_err | (|w_uf);
    end
  assign locks_o = w_locks;
  assign busy_o = |w_locks;
  assign err_o = r_err;
endmodule

// File: tb/tb_rv64g_reg_scoreboard.sv
// tb_rv64g_reg_scoreboard: directed table, corner sequences and random traffic against a count-per-register model.
module tb_rv64g_reg_scoreboard;
  localparam int NR = 64;
  localparam int RW = 6;
  localparam int MAXC = 3;
  logic clk = 1'b0, arst, clr, lv, we;
  logic [RW-1:0] rd;
  logic [1:0] wv;
  logic [2*RW-1:0] wrd;
  logic ready, busy, err;
  logic [NR-1:0] locks;
  int cnt_m[NR];
  bit err_m, s_rdy;
  int n_cmp = 0, n_bad = 0;

  rv64g_reg_scoreboard dut (
    .clk_i(clk), .arst_i(arst), .clear_i(clr), .launch_valid_i(lv), .launch_ready_o(ready),
    .launch_wr_en_i(we), .launch_rd_i(rd), .wb_valid_i(wv), .wb_rd_i(wrd),
    .locks_o(locks), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit c, l, w; int r; bit v0, v1; int r0, r1;
    int q; bit e_rdy, e_lk, e_busy, e_err;
  } vec_t;
  vec_t tv[19];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic logic [NR-1:0] mlocks();
    logic [NR-1:0] v = '0;
    for (int i = 1; i < NR; i++) v[i] = cnt_m[i] != 0;
    return v;
  endfunction

  task automatic idle();
    clr = 0; lv = 0; we = 0; rd = '0; wv = '0; wrd = '0;
  endtask

  task automatic step(input bit c, input bit l, input bit w, input int r,
                      input bit v0, input bit v1, input int r0, input int r1);
    int hits[NR];
    logic [NR-1:0] e;
    int n;
    clr = c; lv = l; we = w; rd = RW'(r); wv = {v1, v0}; wrd = {RW'(r1), RW'(r0)};
    #1;
    s_rdy = !(w && cnt_m[r] == MAXC);
    chk("ready", ready, s_rdy);
    foreach (hits[i]) hits[i] = 0;
    if (v0 && r0 != 0) hits[r0]++;
    if (v1 && r1 != 0) hits[r1]++;
`ifdef RV64G_SCOREBOARD_EARLY_RELEASE_EN
    e = '0;
    for (int i = 1; i < NR; i++) e[i] = cnt_m[i] != 0 && !(hits[i] >= cnt_m[i]);
    chk("locks_early", locks, e);
`endif
    @(posedge clk);
    for (int i = 0; i < NR; i++) begin
      if (c) cnt_m[i] = 0;
      else begin
        n = cnt_m[i] + ((l && s_rdy && w && r != 0 && r == i) ? 1 : 0) - hits[i];
        if (n < 0) begin n = 0; err_m = 1; end
        cnt_m[i] = n;
      end
    end
    if (c) err_m = 0;
    #1 idle();
    #1;
    e = mlocks();
    chk("locks", locks, e);
    chk("busy", busy, |e);
    chk("err", err, err_m);
  endtask

  initial begin
    tv[0]  = '{0,1,1,5, 0,0,0,0,  5, 1,1,1,0};
    tv[1]  = '{0,0,0,0, 1,0,5,0,  5, 1,0,0,0};
    tv[2]  = '{0,1,1,7, 0,0,0,0,  7, 1,1,1,0};
    tv[3]  = '{0,1,1,7, 0,0,0,0,  7, 1,1,1,0};
    tv[4]  = '{0,1,1,7, 0,0,0,0,  7, 1,1,1,0};
    tv[5]  = '{0,1,1,7, 0,0,0,0,  7, 0,1,1,0};
    tv[6]  = '{0,1,1,7, 1,0,7,0,  7, 0,1,1,0};
    tv[7]  = '{0,1,1,8, 0,0,0,0,  8, 1,1,1,0};
    tv[8]  = '{0,0,0,0, 1,1,7,7,  7, 1,0,1,0};
    tv[9]  = '{0,0,0,0, 1,0,8,0,  8, 1,0,0,0};
    tv[10] = '{0,1,1,9, 0,0,0,0,  9, 1,1,1,0};
    tv[11] = '{0,1,1,9, 1,0,9,0,  9, 1,1,1,0};
    tv[12] = '{0,0,0,0, 1,1,9,9,  9, 1,0,0,1};
    tv[13] = '{0,1,1,0, 0,0,0,0,  0, 1,0,0,1};
    tv[14] = '{0,1,0,10,0,0,0,0, 10, 1,0,0,1};
    tv[15] = '{0,1,1,3, 0,0,0,0,  3, 1,1,1,1};
    tv[16] = '{0,1,1,3, 0,0,0,0,  3, 1,1,1,1};
    tv[17] = '{0,1,1,40,0,0,0,0, 40, 1,1,1,1};
    tv[18] = '{1,1,1,12,0,0,0,0, 12, 1,0,0,0};
    foreach (cnt_m[i]) cnt_m[i] = 0;
    err_m = 0;
    idle();
    arst = 1;
    #1;
    chk("rst_locks", locks, '0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) arst = 0;

    foreach (tv[i]) begin
      step(tv[i].c, tv[i].l, tv[i].w, tv[i].r, tv[i].v0, tv[i].v1, tv[i].r0, tv[i].r1);
      chk($sformatf("tv%0d_ready", i), s_rdy, tv[i].e_rdy);
      chk($sformatf("tv%0d_lock", i), locks[tv[i].q], tv[i].e_lk);
      chk($sformatf("tv%0d_busy", i), busy, tv[i].e_busy);
      chk($sformatf("tv%0d_err", i), err, tv[i].e_err);
    end

    step(0, 1, 1, 20, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 21, 21);
    chk("pre_arst_err", err, 1);
    @(negedge clk);
    #2 arst = 1;
    #1;
    chk("arst_locks", locks, '0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err, 0);
    foreach (cnt_m[i]) cnt_m[i] = 0;
    err_m = 0;
    @(negedge clk) arst = 0;

    step(0, 1, 1, 5, 0, 0, 0, 0);
    wv = 2'b01; wrd = {RW'(0), RW'(5)};
    #1;
`ifdef RV64G_SCOREBOARD_EARLY_RELEASE_EN
    chk("er_same_cycle", locks[5], 0);
`else
    chk("er_same_cycle", locks[5], 1);
`endif
    @(posedge clk);
    cnt_m[5] = 0;
    #1 idle();
    #1;
    chk("er_next_cycle", locks[5], 0);

    for (int k = 0; k < 1500; k++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
           $urandom_range(0, 7), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7), $urandom_range(0, 7));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
